gate_scheduler: RTL and testbench
=================================

Name: gate_scheduler

Overview:
- Shares one gate output between NREQ trigger requesters; arbitration is round-robin.
- Latches a rising edge on each requester as a pending request. Grants one request at a time, drives a gate of programmable length, then enforces a programmable dead time.
- Sits in front of the front-end gating logic. It replaces one pulse stretcher per source when sources must not overlap.
- Tags each gate with the winning source index and counts lost requests.

Parameters:
- NREQ, 4, number of requesters (2..16).
- LEN_W, 8, width of gate length field.
- DEAD_W, 4, width of dead-time field.
- WAIT_RST, 240, cycles after reset release during which inputs are ignored.
- SRC_W, $clog2(NREQ), width of the source index.

Ports:
- clk_i  in  1  system clock.
- resetn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  1 = latch and grant requests.
- polarity_i  in  NREQ  per-requester polarity; 1 = positive logic, 0 = negative logic.
- pulse_i  in  NREQ  trigger inputs, synchronous to clk_i.
- gate_len_i  in  LEN_W  gate length in clocks; 0 is treated as 1.
- dead_len_i  in  DEAD_W  dead time in clocks after the gate; 0 means none.
- clr_drop_i  in  1  synchronous clear of drop_cnt_o.
- gate_o  out  1  gate, always positive logic.
- ngate_o  out  1  inverse of gate_o.
- src_o  out  SRC_W  index of the requester owning the current or last gate.
- busy_o  out  1  high when state is not IDLE.
- pending_o  out  NREQ  pending request bits.
- drop_cnt_o  out  16  saturating count of lost requests.

Behaviour:
- Normalisation: p[k] = polarity_i[k] ? pulse_i[k] : ~pulse_i[k]. p_q holds p registered, reset value 0. edge[k] = p[k] & ~p_q[k].
- Reset values (asynchronous): state=WAIT_RST, gate_o=0, ngate_o=1, src_o=0, busy_o=1, pending=0, drop_cnt=0, rr_ptr=0, all counters 0.
- WAIT_RST:
  - Counts WAIT_RST cycles, then moves to IDLE.
  - Edges are neither latched nor counted.
- Request capture (any state except WAIT_RST, only when enable_i=1):
  - edge[k] with pending[k]=0 sets pending[k].
  - edge[k] with pending[k]=1 increments drop_cnt, saturating at 0xFFFF. Several simultaneous drops add 1 each.
  - With enable_i=0, edges are ignored and not counted.
- IDLE, with enable_i=1 and pending!=0:
  - Selects the first set pending bit searching upward from rr_ptr, wrapping modulo NREQ.
  - On that edge: state<=GATE, gate_o<=1, src_o<=k, pending[k]<=0, rr_ptr<=(k+1) mod NREQ.
  - Samples len=max(gate_len_i,1) and dead=dead_len_i.
- Latency: a pulse sampled at edge n sets pending at edge n. When idle, gate_o rises at edge n+1.
- GATE:
  - gate_o stays high for exactly len cycles.
  - Then: dead=0 goes to IDLE, otherwise DEAD. gate_o<=0 on that same edge.
- DEAD:
  - gate_o=0 for exactly dead cycles, then IDLE.
  - A pending request can be granted on the edge leaving DEAD+1, i.e. from IDLE. Minimum spacing between gates is len+dead+1.
- Boundaries:
  - edge[k] coincident with the grant clearing pending[k]: the set wins, no drop.
  - gate_len_i or dead_len_i changing mid-gate: no effect until the next grant.
  - enable_i falling mid-GATE or mid-DEAD: the cycle completes. Pending bits are retained, and no new grant is made until enable_i=1.
  - clr_drop_i coincident with an increment: the clear wins.
  - resetn_i low at any time: outputs return to reset values immediately, and the block re-enters WAIT_RST.
  - src_o holds its value after the gate ends.

Decomposition:
- Shared package gate_sched_pkg holds:
  - the state enum {WAIT_RST, IDLE, GATE, DEAD};
  - DROP_W=16 and DROP_MAX.
- One combinational sub-module, rr_select:
  - inputs: req vector and pointer;
  - outputs: valid and index;
  - rotate then priority-encode.

Test Plan:
- Reset, then pulse_i[0] high at cycle 100 -> no gate, pending_o=0, drop_cnt_o=0. Same pulse at cycle 300 -> gate_o high 1 clock later, src_o=0.
- gate_len_i=5, dead_len_i=3, single pulse on req 2 -> gate_o high exactly 5 cycles, busy_o high 8 cycles, src_o=2.
- Pulses on req 0, 1 and 3 in the same cycle, len=2, dead=0 -> gates in order src 0, 1, 3, each 2 cycles, separated by 1 idle cycle. A later req 0+1 pair gives 1 first because rr_ptr=... no: after the 0,1,3 sequence rr_ptr=0, so the pair grants 0 then 1.
- polarity_i[1]=0, pulse_i[1] idles high then drops for 1 cycle -> one gate, src_o=1.
- Two edges on req 2 while it is pending and blocked by a long gate on req 0 -> drop_cnt_o=1. With drop_cnt at 0xFFFF, a further drop leaves it at 0xFFFF. clr_drop_i -> 0.
- resetn_i low during GATE -> gate_o=0 and ngate_o=1 asynchronously. After release, inputs are ignored for 240 cycles.

Source files
------------

// File: rtl/gate_sched_pkg.sv
// Shared types and constants for the gate scheduler.
//   state_t  : scheduler FSM states (wait after reset, idle, gate, dead time)
//   DROP_W   : width of the lost-request counter
//   DROP_MAX : saturation value of the lost-request counter
package gate_sched_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_RST = 2'd0,
    ST_IDLE     = 2'd1,
    ST_GATE     = 2'd2,
    ST_DEAD     = 2'd3
  } state_t;

  localparam int                DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/gate_scheduler_rr_select.sv
// Round-robin selector (purely combinational).
//   req   : request vector
//   ptr   : requester with highest priority this round
//   valid : at least one request is set
//   index : first set request found searching upward from ptr, wrapping
module rr_select
  import gate_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SRC_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic             valid,
  output logic [SRC_W-1:0] index
);

  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NREQ);

  logic [NREQ-1:0]  rot;
  logic [SRC_W-1:0] off;
  logic [SRC_W:0]   idx_sum;

  // rot[i] is the request sitting i places above ptr (modulo NREQ)
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [SRC_W:0] pos;
    logic [SRC_W:0] wrapped;
    assign pos     = (SRC_W+1)'(gi) + {1'b0, ptr};
    assign wrapped = (pos >= NREQ_W) ? pos - NREQ_W : pos;
    assign rot[gi] = req[wrapped[SRC_W-1:0]];
  end

  // Lowest set bit of the rotated vector wins: scanning downward leaves it last
  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = SRC_W'(i);
      end
    end
  end

  // Undo the rotation
  assign idx_sum = {1'b0, off} + {1'b0, ptr};
  assign index   = (idx_sum >= NREQ_W) ? SRC_W'(idx_sum - NREQ_W) : idx_sum[SRC_W-1:0];

endmodule

// File: rtl/gate_scheduler.sv
// Gate scheduler: shares one gate output between NREQ trigger requesters.
// Rising edges (after polarity normalisation) are latched as pending requests,
// granted round-robin, each grant drives a gate of programmable length followed
// by a programmable dead time. Edges arriving while already pending are counted
// as lost requests.
//   clk_i, resetn_i : clock, asynchronous active-low reset
//   enable_i        : latch and grant requests when high
//   polarity_i      : per-requester polarity (1 = positive logic)
//   pulse_i         : trigger inputs
//   gate_len_i      : gate length in clocks (0 behaves as 1), sampled at grant
//   dead_len_i      : dead time after the gate (0 = none), sampled at grant
//   clr_drop_i      : synchronous clear of the lost-request counter
//   gate_o/ngate_o  : gate and its inverse
//   src_o           : requester owning the current or last gate
//   busy_o          : state is not IDLE
//   pending_o       : pending request bits
//   drop_cnt_o      : saturating count of lost requests
module gate_scheduler
  import gate_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 8,
  parameter int DEAD_W   = 4,
  parameter int WAIT_RST = 240,
  parameter int SRC_W    = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              enable_i,
  input  logic [NREQ-1:0]   polarity_i,
  input  logic [NREQ-1:0]   pulse_i,
  input  logic [LEN_W-1:0]  gate_len_i,
  input  logic [DEAD_W-1:0] dead_len_i,
  input  logic              clr_drop_i,
  output logic              gate_o,
  output logic              ngate_o,
  output logic [SRC_W-1:0]  src_o,
  output logic              busy_o,
  output logic [NREQ-1:0]   pending_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int CNT_W  = (LEN_W > DEAD_W) ? LEN_W : DEAD_W;
  localparam int WAIT_W = $clog2(WAIT_RST + 1);
  localparam int INC_W  = $clog2(NREQ + 1);

  state_t            state_reg;
  logic [NREQ-1:0]   p_norm, p_q_reg, rise;
  logic [NREQ-1:0]   pending_reg, pending_next;
  logic [NREQ-1:0]   grant_mask, set_mask, drop_mask;
  logic [SRC_W-1:0]  rr_ptr_reg, rr_ptr_next, src_reg;
  logic              gate_reg, ngate_reg, busy_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DEAD_W-1:0] dead_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic [DROP_W-1:0] drop_reg, drop_next;
  logic [INC_W-1:0]  drop_inc;
  logic [DROP_W:0]   drop_sum;
  logic [LEN_W-1:0]  len_eff;
  logic              sel_valid, grant, capture;
  logic [SRC_W-1:0]  sel_idx;

  // Polarity normalisation and rising-edge detect
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_norm
    assign p_norm[gi] = polarity_i[gi] ? pulse_i[gi] : ~pulse_i[gi];
  end
  assign rise = p_norm & ~p_q_reg;

  rr_select #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_rr_select (
    .req   (pending_reg),
    .ptr   (rr_ptr_reg),
    .valid (sel_valid),
    .index (sel_idx)
  );

  assign grant   = (state_reg == ST_IDLE) && enable_i && sel_valid;
  assign capture = enable_i && (state_reg != ST_WAIT_RST);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant_mask[gi] = grant && (sel_idx == SRC_W'(gi));
  end

  // A new edge on the requester being granted re-arms it rather than dropping
  assign set_mask     = capture ? rise : '0;
  assign drop_mask    = set_mask & pending_reg & ~grant_mask;
  assign pending_next = (pending_reg & ~grant_mask) | set_mask;

  assign rr_ptr_next = (sel_idx == SRC_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  assign len_eff     = (gate_len_i == '0) ? LEN_W'(1) : gate_len_i;

  // Every simultaneous drop adds one; clear takes precedence over increments
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NREQ; i++) begin
      drop_inc = drop_inc + INC_W'(drop_mask[i]);
    end
    drop_sum = {1'b0, drop_reg} + (DROP_W+1)'(drop_inc);
    if (clr_drop_i)
      drop_next = '0;
    else if (drop_sum > {1'b0, DROP_MAX})
      drop_next = DROP_MAX;
    else
      drop_next = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg   <= ST_WAIT_RST;
      p_q_reg     <= '0;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      src_reg     <= '0;
      gate_reg    <= 1'b0;
      ngate_reg   <= 1'b1;
      busy_reg    <= 1'b1;
      cnt_reg     <= '0;
      dead_reg    <= '0;
      wait_reg    <= '0;
      drop_reg    <= '0;
    end else begin
      p_q_reg     <= p_norm;
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
      case (state_reg)
        ST_WAIT_RST: begin
          if (wait_reg == WAIT_W'(WAIT_RST - 1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (grant) begin
            state_reg  <= ST_GATE;
            busy_reg   <= 1'b1;
            gate_reg   <= 1'b1;
            ngate_reg  <= 1'b0;
            src_reg    <= sel_idx;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= CNT_W'(len_eff);
            dead_reg   <= dead_len_i;
          end
        end
        ST_GATE: begin
          // cnt_reg holds the gate cycles still to run, including this one
          if (cnt_reg == CNT_W'(1)) begin
            gate_reg  <= 1'b0;
            ngate_reg <= 1'b1;
            if (dead_reg == '0) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DEAD;
              cnt_reg   <= CNT_W'(dead_reg);
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_DEAD: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= ST_WAIT_RST;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign gate_o     = gate_reg;
  assign ngate_o    = ngate_reg;
  assign src_o      = src_reg;
  assign busy_o     = busy_reg;
  assign pending_o  = pending_reg;
  assign drop_cnt_o = drop_reg;

endmodule

// File: tb/tb_gate_scheduler.sv
// Scoreboard bench for gate_scheduler: stimulus pushes the expected gate
// (source, gate length, busy length, idle gap before it) into a queue, and a
// monitor pops and compares each time a gate is presented.
module tb_gate_scheduler;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [3:0]  polarity;
  logic [3:0]  pulse;
  logic [7:0]  gate_len;
  logic [3:0]  dead_len;
  logic        clr_drop;
  logic        gate;
  logic        ngate;
  logic [1:0]  src;
  logic        busy;
  logic [3:0]  pending;
  logic [15:0] drop_cnt;

  typedef struct {
    int src;
    int glen;
    int blen;
    int gap;   // -1: not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_quiet = 1'b0;

  gate_scheduler dut (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .enable_i   (enable),
    .polarity_i (polarity),
    .pulse_i    (pulse),
    .gate_len_i (gate_len),
    .dead_len_i (dead_len),
    .clr_drop_i (clr_drop),
    .gate_o     (gate),
    .ngate_o    (ngate),
    .src_o      (src),
    .busy_o     (busy),
    .pending_o  (pending),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: measures each gate and compares against the scoreboard queue
  initial begin : monitor
    exp_t       e;
    logic [1:0] s;
    logic       q;
    logic       gate_prev;
    logic       aborted;
    int         gl, bl, gap, idle_cnt;
    gate_prev = 1'b0;
    idle_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (gate === 1'b1 && !gate_prev) begin
        s = src; q = mon_quiet; gap = idle_cnt;
        gl = 0; bl = 0; aborted = 1'b0;
        while (gate === 1'b1 && !aborted && gl < 1000) begin
          gl++; bl++;
          @(posedge clk); #1;
          if (resetn !== 1'b1) aborted = 1'b1;
        end
        while (busy === 1'b1 && !aborted && bl < 2000) begin
          bl++;
          @(posedge clk); #1;
          if (resetn !== 1'b1) aborted = 1'b1;
        end
        idle_cnt = aborted ? 0 : 1;
        if (!aborted && !q) begin
          $display("gate: src=%0d len=%0d busy=%0d gap=%0d", s, gl, bl, gap);
          check("gate_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gate_src", 32'(s), e.src);
            check("gate_len", gl, e.glen);
            check("busy_len", bl, e.blen);
            if (e.gap >= 0) check("gate_gap", gap, e.gap);
          end
        end
      end else begin
        idle_cnt++;
      end
      gate_prev = gate;
    end
  end

  // Async reset, reset-value checks, input blanking window, first grant on req
  task automatic reset_seq(input int req);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_gate", 32'(gate), 0);
    check("rst_ngate", 32'(ngate), 1);
    check("rst_busy", 32'(busy), 1);
    check("rst_src", 32'(src), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    tick(2);
    resetn   = 1'b1;
    gate_len = 8'd3;
    dead_len = 4'd0;
    tick(100);
    pulse[req] = 1'b1;
    tick(1);
    pulse[req] = 1'b0;
    tick(5);
    check("wait_pending", 32'(pending), 0);
    check("wait_gate", 32'(gate), 0);
    check("wait_busy", 32'(busy), 1);
    tick(193);
    pulse[req] = 1'b1;
    exp_q.push_back('{req, 3, 3, -1});
    tick(1);
    check("first_pending", 32'(pending), 32'(1) << req);
    check("first_gate_lat", 32'(gate), 0);
    pulse[req] = 1'b0;
    tick(1);
    check("first_gate", 32'(gate), 1);
    check("first_ngate", 32'(ngate), 0);
    check("first_src", 32'(src), req);
    tick(8);
  endtask

  initial begin : stimulus
    resetn   = 1'b0;
    enable   = 1'b1;
    polarity = 4'b1111;
    pulse    = 4'b0000;
    gate_len = 8'd3;
    dead_len = 4'd0;
    clr_drop = 1'b0;

    reset_seq(0);                          // rr_ptr -> 1

    // len 5, dead 3 on req 2
    gate_len = 8'd5; dead_len = 4'd3;
    pulse[2] = 1'b1;
    exp_q.push_back('{2, 5, 8, -1});
    tick(1); pulse[2] = 1'b0; tick(20);    // rr_ptr -> 3

    // gate_len 0 behaves as 1
    gate_len = 8'd0; dead_len = 4'd0;
    pulse[3] = 1'b1;
    exp_q.push_back('{3, 1, 1, -1});
    tick(1); pulse[3] = 1'b0; tick(10);    // rr_ptr -> 0

    // Simultaneous 0,1,3 with len 2: served 0,1,3 with one idle cycle between
    gate_len = 8'd2;
    pulse = 4'b1011;
    exp_q.push_back('{0, 2, 2, -1});
    exp_q.push_back('{1, 2, 2, 1});
    exp_q.push_back('{3, 2, 2, 1});
    tick(1); pulse = 4'b0000; tick(15);    // rr_ptr -> 0

    // Pair 0+1: 0 first
    pulse = 4'b0011;
    exp_q.push_back('{0, 2, 2, -1});
    exp_q.push_back('{1, 2, 2, 1});
    tick(1); pulse = 4'b0000; tick(12);    // rr_ptr -> 2

    // Negative polarity on req 1: idle-high line dropping for one cycle
    polarity[1] = 1'b0; pulse[1] = 1'b1;
    tick(3);
    check("pol_no_edge", 32'(pending), 0);
    pulse[1] = 1'b0;
    exp_q.push_back('{1, 2, 2, -1});
    tick(1); pulse[1] = 1'b1; tick(10);
    polarity[1] = 1'b1; pulse[1] = 1'b0;
    tick(2);

    // enable falls mid-gate; length change mid-gate applies at the next grant
    gate_len = 8'd4; dead_len = 4'd2;
    pulse = 4'b1100;
    exp_q.push_back('{2, 4, 6, -1});
    tick(1); pulse = 4'b0000; tick(1);
    check("en_gate_on", 32'(gate), 1);
    enable = 1'b0;
    gate_len = 8'd7; dead_len = 4'd0;
    pulse[0] = 1'b1; tick(1); pulse[0] = 1'b0;
    tick(12);
    check("en_off_gate", 32'(gate), 0);
    check("en_off_busy", 32'(busy), 0);
    check("en_off_pending", 32'(pending), 32'h8);
    exp_q.push_back('{3, 7, 7, -1});
    enable = 1'b1;
    tick(12);                              // rr_ptr -> 0

    // Lost request: second edge on pending req 2 behind a long gate
    gate_len = 8'd40;
    pulse[0] = 1'b1;
    exp_q.push_back('{0, 40, 40, -1});
    exp_q.push_back('{2, 40, 40, 1});
    tick(1); pulse[0] = 1'b0; tick(3);
    pulse[2] = 1'b1; tick(1); pulse[2] = 1'b0; tick(1);
    pulse[2] = 1'b1; tick(1); pulse[2] = 1'b0; tick(1);
    check("drop_one", 32'(drop_cnt), 1);
    check("drop_pending", 32'(pending), 32'h4);
    tick(90);

    // Saturation of the lost-request counter (gates not scoreboarded)
    mon_quiet = 1'b1;
    gate_len = 8'd255;
    for (int i = 0; i < 40000 && drop_cnt != 16'hFFFF; i++) begin
      pulse = ~pulse;
      tick(1);
    end
    check("drop_sat_reached", 32'(drop_cnt), 32'hFFFF);
    repeat (20) begin
      pulse = ~pulse;
      tick(1);
    end
    check("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);
    pulse = 4'b0000;
    tick(2);
    // Clear coincident with fresh drops
    pulse = 4'b1111; clr_drop = 1'b1;
    tick(1);
    clr_drop = 1'b0;
    check("clr_wins", 32'(drop_cnt), 0);
    gate_len = 8'd1;
    for (int i = 0; i < 3000 && (busy || pending != 4'b0000); i++) tick(1);
    check("drain_busy", 32'(busy), 0);
    check("drain_drop", 32'(drop_cnt), 0);
    pulse = 4'b0000;
    tick(3);
    mon_quiet = 1'b0;

    // Reset in the middle of a gate on req 3
    gate_len = 8'd20;
    pulse[3] = 1'b1; tick(1); pulse[3] = 1'b0; tick(3);
    check("pre_rst_gate", 32'(gate), 1);
    reset_seq(1);

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
